// File: rtl/rs422_pkg.sv
// Shared RS422 command-link definitions: sync word, type codes, one-hot commands,
// fixed frame lengths and the receive FSM state type.
package rs422_pkg;

   localparam logic [7:0] SYNC0 = 8'hEB;
   localparam logic [7:0] SYNC1 = 8'h90;

   localparam logic [7:0] TYPE_PLATFORM = 8'h01;
   localparam logic [7:0] TYPE_INJECT   = 8'h02;
   localparam logic [7:0] TYPE_PRESHUT  = 8'h03;
   localparam logic [7:0] TYPE_TIMECODE = 8'h04;
   localparam logic [7:0] TYPE_HK       = 8'h05;

   localparam logic [4:0] CMD_PLATFORM = 5'b00001;
   localparam logic [4:0] CMD_INJECT   = 5'b00010;
   localparam logic [4:0] CMD_PRESHUT  = 5'b00100;
   localparam logic [4:0] CMD_TIMECODE = 5'b01000;
   localparam logic [4:0] CMD_HK       = 5'b10000;

   localparam logic [5:0] LEN_PLATFORM = 6'd13;
   localparam logic [5:0] LEN_INJECT   = 6'd9;
   localparam logic [5:0] LEN_PRESHUT  = 6'd9;
   localparam logic [5:0] LEN_TIMECODE = 6'd25;
   localparam logic [5:0] LEN_HK       = 6'd53;

   typedef enum logic [2:0] {HUNT, SYNC2, TYPE, BODY, CKSUM} rx_state_t;

   // Frame length for a one-hot command, as used by the transmit-side framer.
   function automatic logic [5:0] cmd_frame_len(input logic [4:0] cmd);
      logic [5:0] len;
      case (cmd)
         CMD_PLATFORM: len = LEN_PLATFORM;
         CMD_INJECT:   len = LEN_INJECT;
         CMD_PRESHUT:  len = LEN_PRESHUT;
         CMD_TIMECODE: len = LEN_TIMECODE;
         default:      len = LEN_HK;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/rs422_type_decode.sv
// Combinational map from the frame type byte to one-hot command, frame length
// and a known-type flag.
module rs422_type_decode
   import rs422_pkg::*;
(
   input  logic [7:0] i_type,
   output logic [4:0] o_cmd,
   output logic [5:0] o_len,
   output logic       o_known
);

   always_comb begin
      o_cmd   = CMD_HK;
      o_len   = LEN_HK;
      o_known = 1'b0;
      case (i_type)
         TYPE_PLATFORM: begin o_cmd = CMD_PLATFORM; o_len = LEN_PLATFORM; o_known = 1'b1; end
         TYPE_INJECT:   begin o_cmd = CMD_INJECT;   o_len = LEN_INJECT;   o_known = 1'b1; end
         TYPE_PRESHUT:  begin o_cmd = CMD_PRESHUT;  o_len = LEN_PRESHUT;  o_known = 1'b1; end
         TYPE_TIMECODE: begin o_cmd = CMD_TIMECODE; o_len = LEN_TIMECODE; o_known = 1'b1; end
         TYPE_HK:       begin o_cmd = CMD_HK;       o_len = LEN_HK;       o_known = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/rs422_cmd_frame_rx.sv
// RS422 command-link deframer: sync hunt, type decode, payload streaming and checksum verdict.
// Optional inter-byte timeout enabled by defining RS422_RX_TIMEOUT_EN.
module rs422_cmd_frame_rx
   import rs422_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int TIMEOUT_US = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] pl_data,
   output logic       pl_valid,
   output logic [5:0] pl_index,
   output logic [4:0] frame_cmd,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       busy
);

   rx_state_t  r_state, w_state_nxt;
   logic [4:0] r_cmd, w_cmd_nxt;
   logic [5:0] r_len, w_len_nxt;
   logic [5:0] r_cnt, w_cnt_nxt;
   logic [7:0] r_sum, w_sum_nxt;
   logic [7:0] r_pl_data, w_pl_data_nxt;
   logic [5:0] r_pl_index, w_pl_index_nxt;
   logic       r_pl_valid, w_pl_valid_nxt;
   logic       r_ok, w_ok_nxt;
   logic       r_err, w_err_nxt;
   logic       r_busy;
   logic [4:0] w_dec_cmd;
   logic [5:0] w_dec_len;
   logic       w_dec_known;
   logic       w_tmo;

   rs422_type_decode u_type_decode (
      .i_type  (rx_data),
      .o_cmd   (w_dec_cmd),
      .o_len   (w_dec_len),
      .o_known (w_dec_known)
   );

`ifdef RS422_RX_TIMEOUT_EN
   localparam longint TMO_CYC = (longint'(CLK_HZ) * longint'(TIMEOUT_US)) / 64'd1000000;
   localparam int     GAP_W   = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

   logic [GAP_W-1:0] r_gap;

   // Gap counter idles in HUNT; any strobe restarts the inter-byte window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gap <= '0;
      end else if (rx_valid || r_state == HUNT) begin
         r_gap <= '0;
      end else begin
         r_gap <= r_gap + 1'b1;
      end
   end

   assign w_tmo = (r_state != HUNT) && !rx_valid && (r_gap == GAP_W'(TMO_CYC - 1));
`else
   assign w_tmo = 1'b0;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_cmd_nxt      = r_cmd;
      w_len_nxt      = r_len;
      w_cnt_nxt      = r_cnt;
      w_sum_nxt      = r_sum;
      w_pl_data_nxt  = r_pl_data;
      w_pl_index_nxt = r_pl_index;
      w_pl_valid_nxt = 1'b0;
      w_ok_nxt       = 1'b0;
      w_err_nxt      = 1'b0;
      if (rx_valid) begin
         case (r_state)
            HUNT: begin
               if (rx_data == SYNC0) w_state_nxt = SYNC2;
            end
            SYNC2: begin
               if (rx_data == SYNC1)      w_state_nxt = TYPE;
               else if (rx_data != SYNC0) w_state_nxt = HUNT;
            end
            TYPE: begin
               if (w_dec_known) begin
                  w_cmd_nxt   = w_dec_cmd;
                  w_len_nxt   = w_dec_len;
                  w_sum_nxt   = rx_data;
                  w_cnt_nxt   = 6'd3;
                  w_state_nxt = BODY;
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = HUNT;
               end
            end
            BODY: begin
               // Sync bytes here are ordinary payload; no mid-frame resync.
               w_sum_nxt      = r_sum + rx_data;
               w_pl_valid_nxt = 1'b1;
               w_pl_data_nxt  = rx_data;
               w_pl_index_nxt = r_cnt - 6'd3;
               w_cnt_nxt      = r_cnt + 6'd1;
               if (r_cnt == r_len - 6'd2) w_state_nxt = CKSUM;
            end
            CKSUM: begin
               w_ok_nxt    = (rx_data == r_sum);
               w_err_nxt   = (rx_data != r_sum);
               w_state_nxt = HUNT;
            end
            default: w_state_nxt = HUNT;
         endcase
      end else if (w_tmo) begin
         w_err_nxt   = 1'b1;
         w_state_nxt = HUNT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= HUNT;
         r_cmd      <= CMD_HK;
         r_len      <= '0;
         r_cnt      <= '0;
         r_sum      <= '0;
         r_pl_data  <= '0;
         r_pl_index <= '0;
         r_pl_valid <= 1'b0;
         r_ok       <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cmd      <= w_cmd_nxt;
         r_len      <= w_len_nxt;
         r_cnt      <= w_cnt_nxt;
         r_sum      <= w_sum_nxt;
         r_pl_data  <= w_pl_data_nxt;
         r_pl_index <= w_pl_index_nxt;
         r_pl_valid <= w_pl_valid_nxt;
         r_ok       <= w_ok_nxt;
         r_err      <= w_err_nxt;
         r_busy     <= (w_state_nxt != HUNT);
      end
   end

   assign pl_data   = r_pl_data;
   assign pl_valid  = r_pl_valid;
   assign pl_index  = r_pl_index;
   assign frame_cmd = r_cmd;
   assign frame_ok  = r_ok;
   assign frame_err = r_err;
   assign busy      = r_busy;

endmodule
